// File: rtl/wlo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wlo_pkg
// Purpose  : Shared constants, state encoding and tap-vector type for the
//            word-length optimisation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package wlo_pkg;

    localparam int NUM_CHAN   = 30;
    localparam int WL_W       = 8;
    localparam int MAX_FRAC   = 16;
    localparam int MIN_FRAC   = 0;
    localparam int SETTLE_CYC = 64;
    localparam int MSE_W      = 64;
    localparam int EVAL_W     = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_DECIDE  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        APPLY   = S_APPLY,
        SETTLE  = S_SETTLE,
        MEASURE = S_MEASURE,
        DECIDE  = S_DECIDE,
        DONE    = S_DONE
    } state_t;

    typedef logic [WL_W-1:0] frac_vec_t [NUM_CHAN];

endpackage
`default_nettype wire

// File: rtl/wlo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wlo_sequencer
// Purpose  : Greedy per-tap fractional word-length reduction driven by MSE
//            measurements from the data collector.
// Revision : 1.0 - initial release
// ============================================================================
module wlo_sequencer #(
    parameter int NUM_CHAN   = 30,
    parameter int WL_W       = 8,
    parameter int MAX_FRAC   = 16,
    parameter int MIN_FRAC   = 0,
    parameter int SETTLE_CYC = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            go,
    input  logic            abort,
    input  logic [WL_W-1:0] init_frac,
    input  logic [63:0]     mse_limit,
    output logic [WL_W-1:0] frac_wl [NUM_CHAN],
    output logic            meas_start,
    input  logic [63:0]     mse_data,
    input  logic            mse_valid,
    output logic            busy,
    output logic            done,
    output logic [15:0]     eval_count
);
    import wlo_pkg::*;

    localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [WL_W-1:0]  MAX_WL      = WL_W'(MAX_FRAC);
    localparam logic [WL_W-1:0]  MIN_WL      = WL_W'(MIN_FRAC);
    localparam logic [WL_W-1:0]  ONE_WL      = WL_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CHAN - 1);
    localparam logic [CH_W-1:0]  ONE_CH      = CH_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [WL_W-1:0]   frac_q [NUM_CHAN];
    logic [WL_W-1:0]   frac_d [NUM_CHAN];
    logic [63:0]       mse_q, mse_d;
    logic [15:0]       eval_q, eval_d;
    logic              meas_start_q, meas_start_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic              step_req;
    logic              adv_req;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        settle_d     = settle_q;
        frac_d       = frac_q;
        mse_d        = mse_q;
        eval_d       = eval_q;
        meas_start_d = 1'b0;
        done_d       = 1'b0;
        step_req     = 1'b0;
        adv_req      = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    for (int i = 0; i < NUM_CHAN; i++) begin
                        frac_d[i] = init_frac;
                    end
                    ch_d    = '0;
                    eval_d  = '0;
                    state_d = APPLY;
                end
            end
            APPLY: step_req = 1'b1;
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d      = MEASURE;
                    meas_start_d = 1'b1;
                    eval_d       = (eval_q == 16'hFFFF) ? eval_q : eval_q + 16'd1;
                end else begin
                    settle_d = settle_q - ONE_CNT;
                end
            end
            MEASURE: begin
                // The result strobe is only trusted once the start pulse has gone out.
                if (mse_valid && !meas_start_q) begin
                    mse_d   = mse_data;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (mse_q <= mse_limit) begin
                    step_req = 1'b1;
                end else begin
                    frac_d[ch_q] = frac_q[ch_q] + ONE_WL;
                    adv_req      = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An accepted step folds straight into the next decrement so it lands one cycle after DECIDE.
        if (step_req) begin
            if (frac_q[ch_q] == MIN_WL) begin
                adv_req = 1'b1;
            end else begin
                frac_d[ch_q] = frac_q[ch_q] - ONE_WL;
                settle_d     = SETTLE_INIT;
                state_d      = SETTLE;
            end
        end

        if (adv_req) begin
            if (ch_q == LAST_CH) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                ch_d    = ch_q + ONE_CH;
                state_d = APPLY;
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            frac_d       = frac_q;
            meas_start_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            settle_q     <= '0;
            mse_q        <= '0;
            eval_q       <= '0;
            meas_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                frac_q[i] <= MAX_WL;
            end
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            settle_q     <= settle_d;
            mse_q        <= mse_d;
            eval_q       <= eval_d;
            meas_start_q <= meas_start_d;
            done_q       <= done_d;
            busy_q       <= (state_d != IDLE);
            frac_q       <= frac_d;
        end
    end

    assign frac_wl    = frac_q;
    assign meas_start = meas_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign eval_count = eval_q;

endmodule
`default_nettype wire
